mux_scan_ctrl: RTL and testbench

Sequential scan controller for the 4:1 mux stage. It drives the mux select lines `sel` through every channel in order. It holds each select for a programmable settle time, samples the mux output `y` at the end of that time, and assembles the samples into a parallel `frame` word. It sits around the mux: it feeds the mux select input and consumes the mux output. The result is a time-multiplexed serial-to-parallel capture with a start/done handshake.

---
 rtl/mux_scan_ctrl.sv | 119 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mux_scan_ctrl
// Description : Steps a 4:1 mux select through every channel, samples y after
//               a programmable dwell and publishes the samples as a frame word.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_scan_ctrl #(
    parameter int SEL_W = 2,
    parameter int DWELL = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    y,
    output logic [SEL_W-1:0]        sel,
    output logic                    busy,
    output logic                    done,
    output logic [(1<<SEL_W)-1:0]   frame
);

    localparam int                 C_N        = 1 << SEL_W;
    localparam int                 C_CNT_W    = (DWELL < 2) ? 1 : $clog2(DWELL + 1);
    localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]   C_LAST_SEL = SEL_W'(C_N - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t             r_state,  w_state_nxt;
    logic [C_CNT_W-1:0] r_cnt,    w_cnt_nxt;
    logic [SEL_W-1:0]   r_sel,    w_sel_nxt;
    logic [C_N-1:0]     r_shadow, w_shadow_nxt;
    logic [C_N-1:0]     r_frame,  w_frame_nxt;
    logic               r_busy,   w_busy_nxt;
    logic               r_done,   w_done_nxt;
    logic [C_N-1:0]     w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_shadow <= '0;
            r_frame  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_sel    <= w_sel_nxt;
            r_shadow <= w_shadow_nxt;
            r_frame  <= w_frame_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_sel_nxt    = r_sel;
        w_shadow_nxt = r_shadow;
        w_frame_nxt  = r_frame;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        // Shadow with the current channel's sample merged in; on the last
        // channel this is exactly the completed frame.
        w_capture        = r_shadow;
        w_capture[r_sel] = y;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt  = S_SCAN;
                    w_busy_nxt   = 1'b1;
                    w_sel_nxt    = '0;
                    w_cnt_nxt    = '0;
                    w_shadow_nxt = '0;
                end
            end
            S_SCAN: begin
                if (r_cnt < C_LAST_CNT) begin
                    w_cnt_nxt = r_cnt + C_CNT_W'(1);
                end else begin
                    w_cnt_nxt    = '0;
                    w_shadow_nxt = w_capture;
                    if (r_sel != C_LAST_SEL) begin
                        w_sel_nxt = r_sel + SEL_W'(1);
                    end else begin
                        w_frame_nxt  = w_capture;
                        w_done_nxt   = 1'b1;
                        w_sel_nxt    = '0;
                        w_shadow_nxt = '0;
                        if (!cont) begin
                            w_state_nxt = S_IDLE;
                            w_busy_nxt  = 1'b0;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_sel_nxt   = '0;
            end
        endcase
    end

    assign sel   = r_sel;
    assign busy  = r_busy;
    assign done  = r_done;
    assign frame = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_mux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_scan_ctrl
// Description : Directed bench for mux_scan_ctrl with a behavioural 4:1 mux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       start1;
    logic       cont;
    logic [3:0] d;
    logic       y0;
    logic       y1;
    logic [1:0] sel0;
    logic [1:0] sel1;
    logic       busy0;
    logic       busy1;
    logic       done0;
    logic       done1;
    logic [3:0] frame0;
    logic [3:0] frame1;

    int n_tests = 0;
    int n_fail  = 0;

    assign y0 = d[sel0];
    assign y1 = d[sel1];

    mux_scan_ctrl #(.SEL_W(2), .DWELL(4)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .cont  (cont),
        .y     (y0),
        .sel   (sel0),
        .busy  (busy0),
        .done  (done0),
        .frame (frame0)
    );

    mux_scan_ctrl #(.SEL_W(2), .DWELL(1)) u_dut_d1 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start1),
        .cont  (1'b0),
        .y     (y1),
        .sel   (sel1),
        .busy  (busy1),
        .done  (done1),
        .frame (frame1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        logic exp_done;

        // Reset held with start asserted
        rst_n  = 1'b0;
        start  = 1'b1;
        start1 = 1'b0;
        cont   = 1'b0;
        d      = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_sel",   32'(sel0),   32'd0);
            check("rst_busy",  32'(busy0),  32'd0);
            check("rst_done",  32'(done0),  32'd0);
            check("rst_frame", 32'(frame0), 32'd0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", 32'(busy0), 32'd0);
            check("idle_sel",  32'(sel0),  32'd0);
        end

        // Single scan, D=0001
        d = 4'b0001;
        start_pulse();
        check("s_sel_e0",  32'(sel0),  32'd0);
        check("s_busy_e0", 32'(busy0), 32'd1);
        for (int e = 1; e <= 17; e++) begin
            tick();
            if (e < 16) begin
                check("s_sel",  32'(sel0),  32'(e / 4));
                check("s_busy", 32'(busy0), 32'd1);
                check("s_done", 32'(done0), 32'd0);
            end else if (e == 16) begin
                check("s_done16",  32'(done0),  32'd1);
                check("s_frame16", 32'(frame0), 32'h1);
                check("s_busy16",  32'(busy0),  32'd0);
                check("s_sel16",   32'(sel0),   32'd0);
            end else begin
                check("s_done17", 32'(done0), 32'd0);
            end
        end

        // Continuous mode, D=1010, cont dropped before the third frame ends
        d    = 4'b1010;
        cont = 1'b1;
        start_pulse();
        for (int e = 1; e <= 60; e++) begin
            if (e == 41) cont = 1'b0;
            tick();
            exp_done = (e == 16 || e == 32 || e == 48);
            check("c_done", 32'(done0), 32'(exp_done));
            if (exp_done) check("c_frame", 32'(frame0), 32'hA);
            if (e == 47)  check("c_busy47", 32'(busy0), 32'd1);
            if (e == 48)  check("c_busy48", 32'(busy0), 32'd0);
        end

        // Data change after channel 1 was sampled
        d = 4'b0001;
        start_pulse();
        for (int e = 1; e <= 17; e++) begin
            if (e == 9) d = 4'b1111;
            tick();
            check("dc_done", 32'(done0), 32'(e == 16));
            if (e == 16) check("dc_frame", 32'(frame0), 32'hD);
        end

        // Start held over several edges and again mid-scan
        d     = 4'b0110;
        start = 1'b1;
        tick();
        tick();
        tick();
        start = 1'b0;
        for (int e = 3; e <= 30; e++) begin
            if (e == 7) start = 1'b1;
            if (e == 9) start = 1'b0;
            tick();
            check("st_done", 32'(done0), 32'(e == 16));
            if (e == 16) check("st_frame", 32'(frame0), 32'h6);
        end

        // DWELL=1 instance with start held high: done every 5 cycles
        start1 = 1'b1;
        tick();
        check("d1_busy_e0", 32'(busy1), 32'd1);
        for (int e = 1; e <= 20; e++) begin
            tick();
            exp_done = (e >= 4) && (((e - 4) % 5) == 0);
            check("d1_done", 32'(done1), 32'(exp_done));
            if (exp_done) check("d1_frame", 32'(frame1), 32'h6);
            if (e < 4) check("d1_sel", 32'(sel1), 32'(e));
        end
        start1 = 1'b0;

        // Reset mid-scan
        d = 4'b1111;
        start_pulse();
        for (int e = 1; e <= 9; e++) tick();
        check("mr_busy_pre",  32'(busy0),  32'd1);
        check("mr_sel_pre",   32'(sel0),   32'd2);
        check("mr_frame_pre", 32'(frame0), 32'h6);
        #2;
        rst_n = 1'b0;
        #1;
        check("mr_sel",   32'(sel0),   32'd0);
        check("mr_busy",  32'(busy0),  32'd0);
        check("mr_done",  32'(done0),  32'd0);
        check("mr_frame", 32'(frame0), 32'd0);
        check("mr_frame1", 32'(frame1), 32'd0);
        #3;
        rst_n = 1'b1;
        for (int e = 0; e < 20; e++) begin
            tick();
            check("mr_post_done", 32'(done0),  32'd0);
            check("mr_post_busy", 32'(busy0),  32'd0);
        end
        check("mr_post_frame", 32'(frame0), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
